// File: rtl/game_pkg.sv
// Shared FSM state type, checker result codes and LFSR seed/step for the reaction-game sequencer.
// Pure declarations; no latency or flow control.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_WAIT = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  localparam logic [1:0]  GLP_HIT   = 2'b11;
  localparam logic [1:0]  GLP_MISS  = 2'b01;
  localparam logic [1:0]  GLP_NONE  = 2'b00;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Fibonacci step, taps 16,14,13,11.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    lfsr_next = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, advances every cycle, reloads the seed rather than hold zero.
// Latency: new value every clk; no backpressure.
module lfsr16
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] state
);

  logic [15:0] state_nxt;

  assign state_nxt = lfsr_next(state);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   state <= LFSR_SEED;
    else if (state_nxt == 16'd0) state <= LFSR_SEED;
    else                         state <= state_nxt;
  end

endmodule

// File: rtl/round_sequencer.sv
// Game round sequencer: idle gap, reaction window, score/lives bookkeeping; all outputs registered, no backpressure.
// ROUND_SPEEDUP_EN: window shrinks with score (latched at window start).
module round_sequencer
  import game_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = 50000000,
  parameter int unsigned GAP_CYCLES    = 12500000,
  parameter int unsigned LIVES_INIT    = 3,
  parameter int unsigned SCORE_W       = 8,
  parameter int unsigned WINDOW_STEP   = 1000000,
  parameter int unsigned WINDOW_MIN    = 10000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         give_lose_point,
  output logic [1:0]         random_num,
  output logic               start_checks,
  output logic               clock_done,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         lives,
  output logic               game_over
);

  localparam logic [31:0]        GAP_LAST   = 32'(GAP_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [1:0]         LIVES_LOAD = 2'(LIVES_INIT);

  state_t             state, state_d;
  logic [15:0]        lfsr;
  logic [31:0]        gap_cnt, gap_cnt_d, win_cnt, win_cnt_d, win_last;
  logic               first_wait, first_wait_d;
  logic [1:0]         random_num_d, lives_d;
  logic               start_checks_d, clock_done_d, game_over_d;
  logic [SCORE_W-1:0] score_d;
  logic               gap_done, sampled, hit, miss;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .state (lfsr)
  );

`ifdef ROUND_SPEEDUP_EN
  logic [31:0] cut, win_last_d;

  assign cut = 32'(score) * WINDOW_STEP;

  always_comb begin
    if (cut >= WINDOW_CYCLES - WINDOW_MIN) win_last_d = WINDOW_MIN - 1;
    else                                   win_last_d = WINDOW_CYCLES - cut - 1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         win_last <= 32'(WINDOW_CYCLES - 1);
    else if (gap_done) win_last <= win_last_d;
  end
`else
  logic unused_speedup_cfg;

  assign win_last           = 32'(WINDOW_CYCLES - 1);
  assign unused_speedup_cfg = ^{WINDOW_STEP, WINDOW_MIN};
`endif

  assign gap_done = (state == ST_GAP) && (gap_cnt == GAP_LAST);
  // The checker's code is stale during the first window cycle.
  assign sampled  = (state == ST_WAIT) && !first_wait;
  assign hit      = sampled && (give_lose_point == GLP_HIT);
  assign miss     = sampled && (give_lose_point == GLP_MISS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      gap_cnt      <= '0;
      win_cnt      <= '0;
      first_wait   <= 1'b0;
      random_num   <= '0;
      start_checks <= 1'b0;
      clock_done   <= 1'b0;
      score        <= '0;
      lives        <= '0;
      game_over    <= 1'b0;
    end else begin
      state        <= state_d;
      gap_cnt      <= gap_cnt_d;
      win_cnt      <= win_cnt_d;
      first_wait   <= first_wait_d;
      random_num   <= random_num_d;
      start_checks <= start_checks_d;
      clock_done   <= clock_done_d;
      score        <= score_d;
      lives        <= lives_d;
      game_over    <= game_over_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE, ST_OVER: if (start) state_d = ST_GAP;
      ST_GAP:           if (gap_done) state_d = ST_WAIT;
      ST_WAIT: begin
        if (hit)       state_d = ST_GAP;
        else if (miss) state_d = (lives == 2'd1) ? ST_OVER : ST_GAP;
      end
      default:         state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gap_cnt_d      = gap_cnt;
    win_cnt_d      = win_cnt;
    first_wait_d   = 1'b0;
    random_num_d   = random_num;
    start_checks_d = start_checks;
    clock_done_d   = clock_done;
    score_d        = score;
    lives_d        = lives;
    game_over_d    = game_over;
    case (state)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          score_d     = '0;
          lives_d     = LIVES_LOAD;
          game_over_d = 1'b0;
          gap_cnt_d   = '0;
        end
      end
      ST_GAP: begin
        if (gap_done) begin
          random_num_d   = lfsr[1:0];
          start_checks_d = 1'b1;
          win_cnt_d      = '0;
          first_wait_d   = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt + 32'd1;
        end
      end
      ST_WAIT: begin
        if (hit || miss) begin
          start_checks_d = 1'b0;
          clock_done_d   = 1'b0;
          gap_cnt_d      = '0;
          if (hit && (score != SCORE_MAX)) score_d = score + 1'b1;
          if (miss) begin
            lives_d = lives - 2'd1;
            if (lives == 2'd1) game_over_d = 1'b1;
          end
        end else if (!clock_done) begin
          // Timer freezes once the window has expired.
          win_cnt_d = win_cnt + 32'd1;
          if (win_cnt_d == win_last) clock_done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
